// File: rtl/debug_link_pkg.sv
// Shared definitions for the host-side debug link.
// Holds packet opcodes, status byte codes, the harness command codes and
// the issuer state encoding used by debug_cmd_issuer.
package debug_link_pkg;

  // Packet opcodes (0x01..0x0F are harness commands, carried in opcode[3:0])
  localparam logic [7:0] OP_PROG  = 8'h10;
  localparam logic [7:0] OP_CLEAR = 8'h20;

  // Status bytes returned to the host
  localparam logic [7:0] ST_CMD_OK  = 8'hA0;  // OR'ed with the command code
  localparam logic [7:0] ST_PROG_OK = 8'hB0;
  localparam logic [7:0] ST_CLR_OK  = 8'hC0;
  localparam logic [7:0] ST_TIMEOUT = 8'hE0;  // OR'ed with the command code
  localparam logic [7:0] ST_RANGE   = 8'hE1;
  localparam logic [7:0] ST_BADOP   = 8'hEF;

  // Harness command codes
  localparam logic [3:0] RUN   = 4'd1;
  localparam logic [3:0] STEPI = 4'd2;
  localparam logic [3:0] STEPC = 4'd3;

  typedef enum logic [3:0] {
    IDLE,
    PROG_AH,
    PROG_AL,
    PROG_LEN,
    PROG_DATA,
    CMD_ISSUE,
    CMD_WAIT,
    CLEAR,
    RESP
  } state_t;

endpackage

// File: rtl/debug_cmd_issuer.sv
// Host-side initiator for the debug harness.
// Parses host bytes into packets (CMD / PROG / CLEAR), drives the harness
// command, code-ROM write and ROM-clear inputs, and returns one status byte
// per packet on the transmit stream.
// Ports:
//   clk, reset                         clock, async active-high reset
//   rx_data/rx_valid/rx_ready          host byte stream in
//   tx_data/tx_valid/tx_ready          status byte stream out
//   debug_cmd, command_complete        harness command / done strobe
//   program_rom_mode, code_rom_addr,
//   code_rom_data                      one-cycle ROM write strobe + payload
//   reset_code_rom_n                   active-low ROM clear
//   busy                               high whenever not IDLE
module debug_cmd_issuer
  import debug_link_pkg::*;
#(
  parameter int ROM_BYTES      = 32,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        debug_cmd,
  input  logic              command_complete,
  output logic              program_rom_mode,
  output logic [ADDR_W-1:0] code_rom_addr,
  output logic [7:0]        code_rom_data,
  output logic              reset_code_rom_n,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0]  ROM_LIM  = (ADDR_W + 1)'(ROM_BYTES);

  state_t              state_q, state_d;
  logic [3:0]          code_q, code_d;
  logic [3:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                range_q, range_d;

  logic [3:0]          debug_cmd_q, debug_cmd_d;
  logic                prm_q, prm_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [7:0]          rom_data_q, rom_data_d;
  logic                rom_rst_n_q, rom_rst_n_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;

  logic                in_range;

  assign in_range = {1'b0, addr_q} < ROM_LIM;

  assign rx_ready = (state_q == IDLE) || (state_q == PROG_AH) || (state_q == PROG_AL) ||
                    (state_q == PROG_LEN) || (state_q == PROG_DATA);
  assign busy     = (state_q != IDLE);

  assign debug_cmd        = debug_cmd_q;
  assign program_rom_mode = prm_q;
  assign code_rom_addr    = rom_addr_q;
  assign code_rom_data    = rom_data_q;
  assign reset_code_rom_n = rom_rst_n_q;
  assign tx_valid         = tx_valid_q;
  assign tx_data          = tx_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      range_q     <= 1'b0;
      debug_cmd_q <= '0;
      prm_q       <= 1'b0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      rom_rst_n_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      range_q     <= range_d;
      debug_cmd_q <= debug_cmd_d;
      prm_q       <= prm_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      rom_rst_n_q <= rom_rst_n_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    range_d     = range_q;
    debug_cmd_d = '0;
    prm_d       = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_data_d  = rom_data_q;
    rom_rst_n_d = rom_rst_n_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if ((rx_data >= 8'h01) && (rx_data <= 8'h0F)) begin
            // debug_cmd is registered here so it is visible during CMD_ISSUE only
            code_d      = rx_data[3:0];
            debug_cmd_d = rx_data[3:0];
            state_d     = CMD_ISSUE;
          end else if (rx_data == OP_PROG) begin
            state_d = PROG_AH;
          end else if (rx_data == OP_CLEAR) begin
            rom_rst_n_d = 1'b0;
            cnt_d       = '0;
            state_d     = CLEAR;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = ST_BADOP;
            state_d    = RESP;
          end
        end
      end
      PROG_AH: begin
        if (rx_valid) begin
          hi_d    = rx_data[3:0];
          state_d = PROG_AL;
        end
      end
      PROG_AL: begin
        if (rx_valid) begin
          addr_d  = ADDR_W'({hi_q, rx_data});
          state_d = PROG_LEN;
        end
      end
      PROG_LEN: begin
        if (rx_valid) begin
          len_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = PROG_DATA;
        end
      end
      PROG_DATA: begin
        if (rx_valid) begin
          if (in_range) begin
            prm_d      = 1'b1;
            rom_addr_d = addr_q;
            rom_data_d = rx_data;
          end else begin
            range_d = 1'b1;
          end
          addr_d = addr_q + ADDR_W'(1);
          len_d  = len_q - 9'd1;
          if (len_q == 9'd1) begin
            // the current byte's range check must count toward the status
            tx_valid_d = 1'b1;
            tx_data_d  = (range_q || !in_range) ? ST_RANGE : ST_PROG_OK;
            state_d    = RESP;
          end
        end
      end
      CMD_ISSUE: begin
        cnt_d   = '0;
        state_d = CMD_WAIT;
      end
      CMD_WAIT: begin
        if (command_complete) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ST_CMD_OK | {4'h0, code_q};
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ST_TIMEOUT | {4'h0, code_q};
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          rom_rst_n_d = 1'b1;
          tx_valid_d  = 1'b1;
          tx_data_d   = ST_CLR_OK;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          range_d    = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_cmd_issuer.sv
module tb_debug_cmd_issuer;
  import debug_link_pkg::*;

  localparam int ROM_BYTES = 32;
  localparam int ADDR_W    = 12;
  localparam int TMO       = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [3:0]        debug_cmd;
  logic              command_complete = 1'b0;
  logic              program_rom_mode;
  logic [ADDR_W-1:0] code_rom_addr;
  logic [7:0]        code_rom_data;
  logic              reset_code_rom_n;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]        tx_exp[$];
  logic [ADDR_W-1:0] wa_exp[$];
  logic [7:0]        wd_exp[$];

  logic harness_en = 1'b0;
  logic p0 = 1'b0, p1 = 1'b0;

  debug_cmd_issuer #(.ROM_BYTES(ROM_BYTES), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .debug_cmd(debug_cmd), .command_complete(command_complete),
    .program_rom_mode(program_rom_mode), .code_rom_addr(code_rom_addr),
    .code_rom_data(code_rom_data), .reset_code_rom_n(reset_code_rom_n),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Harness model: completion strobe is sampled two cycles after debug_cmd.
  always @(negedge clk) begin
    command_complete = harness_en && p1;
    p1 = p0;
    p0 = (debug_cmd != 4'd0);
  end

  // Scoreboard monitor for ROM writes and status bytes.
  always @(negedge clk) begin
    if (!reset && program_rom_mode) begin
      total++;
      if (wa_exp.size() == 0) begin
        bad++;
        $display("FAIL rom_write_unexpected: got addr=%0d data=%02h, expected none", code_rom_addr, code_rom_data);
      end else begin
        logic [ADDR_W-1:0] ea;
        logic [7:0] ed;
        ea = wa_exp.pop_front();
        ed = wd_exp.pop_front();
        if (code_rom_addr !== ea || code_rom_data !== ed) begin
          bad++;
          $display("FAIL rom_write: got addr=%0d data=%02h, expected addr=%0d data=%02h", code_rom_addr, code_rom_data, ea, ed);
        end
      end
    end
    if (!reset && tx_valid && tx_ready) begin
      total++;
      if (tx_exp.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got %02h, expected none", tx_data);
      end else begin
        logic [7:0] et;
        et = tx_exp.pop_front();
        if (tx_data !== et) begin
          bad++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_data, et);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (rx_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    rx_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %02h not accepted, expected acceptance", b);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (!busy && !tx_valid) done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%0b tx_valid=%0b, expected idle", busy, tx_valid);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (debug_cmd !== 4'd0 || program_rom_mode !== 1'b0 || code_rom_addr !== '0 ||
        code_rom_data !== 8'h00 || reset_code_rom_n !== 1'b1 || tx_valid !== 1'b0 ||
        tx_data !== 8'h00 || busy !== 1'b0 || rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: got cmd=%0h prm=%0b addr=%0h data=%02h rstn=%0b txv=%0b txd=%02h busy=%0b rdy=%0b, expected 0 0 0 00 1 0 00 0 1",
               tag, debug_cmd, program_rom_mode, code_rom_addr, code_rom_data, reset_code_rom_n,
               tx_valid, tx_data, busy, rx_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_prog();
    logic [7:0] d[4] = '{8'h13, 8'h05, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      wa_exp.push_back(ADDR_W'(4 + i));
      wd_exp.push_back(d[i]);
    end
    tx_exp.push_back(8'hB0);
    send_byte(OP_PROG); send_byte(8'h00); send_byte(8'h04); send_byte(8'h04);
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i]);
      repeat (2) @(negedge clk);  // rx stall between bytes
    end
    wait_idle(20);
    total++;
    if (wa_exp.size() != 0) begin
      bad++;
      $display("FAIL prog_writes: got %0d missing writes, expected 0", wa_exp.size());
    end
  endtask

  task automatic test_cmd(input logic [3:0] code, input logic [7:0] status);
    int first = -1, txat = -1, hi = 0;
    harness_en = 1'b1;
    tx_exp.push_back(status);
    send_byte({4'h0, code});
    for (int k = 0; k < 20 && txat < 0; k++) begin
      @(negedge clk);
      if (debug_cmd != 0) begin
        hi++;
        if (first < 0) first = k;
        total++;
        if (debug_cmd !== code) begin
          bad++;
          $display("FAIL cmd_code: got %0h, expected %0h", debug_cmd, code);
        end
      end
      if (tx_valid) txat = k;
    end
    total++;
    if (hi != 1 || txat - first != 3) begin
      bad++;
      $display("FAIL cmd_timing: got pulse=%0d latency=%0d, expected pulse=1 latency=3", hi, txat - first);
    end
    wait_idle(10);
    harness_en = 1'b0;
  endtask

  task automatic test_timeout();
    int first = -1, txat = -1, hi = 0;
    harness_en = 1'b0;
    tx_exp.push_back(8'hE3);
    send_byte({4'h0, STEPC});
    for (int k = 0; k < TMO + 100 && txat < 0; k++) begin
      @(negedge clk);
      if (debug_cmd != 0) begin
        hi++;
        if (first < 0) first = k;
      end
      if (tx_valid) txat = k;
    end
    total++;
    if (hi != 1 || first < 0 || txat - first != TMO + 1) begin
      bad++;
      $display("FAIL timeout_timing: got pulse=%0d latency=%0d, expected pulse=1 latency=%0d", hi, txat - first, TMO + 1);
    end
    wait_idle(10);
    repeat (4) @(negedge clk);
    total++;
    if (debug_cmd !== 4'd0) begin
      bad++;
      $display("FAIL timeout_cmd_idle: got %0h, expected 0", debug_cmd);
    end
  endtask

  task automatic test_range();
    wa_exp.push_back(ADDR_W'(30)); wd_exp.push_back(8'hA1);
    wa_exp.push_back(ADDR_W'(31)); wd_exp.push_back(8'hA2);
    tx_exp.push_back(8'hE1);
    send_byte(OP_PROG); send_byte(8'hF0); send_byte(8'h1E); send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    wait_idle(20);
    total++;
    if (wa_exp.size() != 0) begin
      bad++;
      $display("FAIL range_writes: got %0d missing writes, expected 0", wa_exp.size());
    end
    // range flag must not leak into the next packet
    wa_exp.push_back(ADDR_W'(0)); wd_exp.push_back(8'h55);
    tx_exp.push_back(8'hB0);
    send_byte(OP_PROG); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h55);
    wait_idle(20);
  endtask

  task automatic test_clear_badop();
    int low = 0, act = 0;
    tx_exp.push_back(8'hC0);
    send_byte(OP_CLEAR);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!reset_code_rom_n) low++;
    end
    total++;
    if (low != 2) begin
      bad++;
      $display("FAIL clear_pulse: got %0d cycles low, expected 2", low);
    end
    tx_exp.push_back(8'hEF);
    send_byte(8'h7F);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (debug_cmd != 0 || program_rom_mode || !reset_code_rom_n) act++;
    end
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL badop_activity: got %0d active cycles, expected 0", act);
    end
    wait_idle(10);
  endtask

  task automatic test_reset_midpacket();
    int seen = 0;
    tx_ready = 1'b0;
    wa_exp.push_back(ADDR_W'(0)); wd_exp.push_back(8'h11);
    wa_exp.push_back(ADDR_W'(1)); wd_exp.push_back(8'h22);
    send_byte(OP_PROG); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    #1 reset = 1'b1;
    #2;
    check_reset_values("reset_midpacket");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    total++;
    if (seen != 0 || wa_exp.size() != 0) begin
      bad++;
      $display("FAIL reset_no_tx: got tx cycles=%0d pending writes=%0d, expected 0 0", seen, wa_exp.size());
    end
    tx_ready = 1'b1;
    test_cmd(STEPI, 8'hA2);
  endtask

  initial begin
    test_reset();
    test_prog();
    test_cmd(RUN, 8'hA1);
    test_timeout();
    test_range();
    test_clear_badop();
    test_reset_midpacket();
    repeat (3) @(negedge clk);
    total++;
    if (tx_exp.size() != 0 || wa_exp.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got tx=%0d wr=%0d pending, expected 0 0", tx_exp.size(), wa_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_cmd_issuer.md
Name: debug_cmd_issuer

Overview:
Host-side initiator for the debug harness interface. It parses a byte stream from the host link (UART/Python bridge) into packets and uses them to program the code ROM, clear the ROM, and issue debug commands. For each command it waits for command_complete and returns one status byte on a transmit stream. It sits between the host link and the debug harness and drives every harness input except clk and reset_n.

Parameters:
ROM_BYTES, 32, number of writable code-ROM bytes; write addresses >= ROM_BYTES are dropped.
ADDR_W, 12, width of code_rom_addr.
TIMEOUT_CYCLES, 1024, cycles to wait for command_complete before reporting a timeout.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data  in  8  host byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid && rx_ready
tx_data  out  8  status byte to host
tx_valid  out  1  tx_data valid
tx_ready  in  1  host accepts the byte when tx_valid && tx_ready
debug_cmd  out  4  command code to harness; 0 when idle
command_complete  in  1  harness done strobe
program_rom_mode  out  1  ROM write strobe, one cycle per byte
code_rom_addr  out  ADDR_W  ROM byte address
code_rom_data  out  8  ROM byte data
reset_code_rom_n  out  1  active-low ROM clear
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - debug_cmd = 0, program_rom_mode = 0, code_rom_addr = 0, code_rom_data = 0.
  - reset_code_rom_n = 1, tx_valid = 0, tx_data = 0, busy = 0.
  - rx_ready is a state decode, so it reads 1 after reset.
  - Reset asserted mid-packet abandons the packet silently; no status byte is sent.
- All outputs are registered except rx_ready and busy, which decode the state.
- rx_ready = 1 only in IDLE, PROG_AH, PROG_AL, PROG_LEN and PROG_DATA.
- Packets (first byte is the opcode):
  - 0x01..0x0F, CMD: issue debug_cmd = opcode[3:0].
  - 0x10, PROG: followed by addr_hi (bits [3:0] used), addr_lo, len (0 means 256), then len data bytes.
  - 0x20, CLEAR: clear the code ROM.
  - 0x00 or any other value: bad opcode; status 0xEF.
- States:
  - IDLE: on an rx handshake, decode the opcode and go to CMD_ISSUE, PROG_AH, CLEAR or RESP(0xEF).
  - PROG_AH → PROG_AL → PROG_LEN: one rx handshake each. Latch addr = {addr_hi[3:0], addr_lo}; load the remaining-byte counter (9 bits).
  - PROG_DATA: each rx handshake registers program_rom_mode = 1, code_rom_addr = addr, code_rom_data = byte, all valid for the next cycle only.
    - addr increments modulo 2^ADDR_W.
    - If addr >= ROM_BYTES, the strobe is suppressed and a sticky range-error flag is set.
    - After the last byte: RESP(0xB0), or RESP(0xE1) if the flag is set. The flag clears on entering IDLE.
    - rx stalls (rx_valid low) do not create write strobes.
  - CMD_ISSUE: debug_cmd = code for exactly one cycle, then forced back to 0; go to CMD_WAIT.
  - CMD_WAIT: count cycles.
    - command_complete = 1 → RESP(0xA0 | code).
    - Counter reaches TIMEOUT_CYCLES → RESP(0xE0 | code).
    - If both happen in the same cycle, completion wins.
    - command_complete arriving in the CMD_ISSUE cycle is ignored.
    - Expected latency with the harness: complete arrives 2 cycles after debug_cmd.
  - CLEAR: reset_code_rom_n = 0 for 2 cycles, then RESP(0xC0).
  - RESP: tx_valid = 1 with tx_data held stable until tx_ready; on the handshake tx_valid = 0 and go to IDLE. No rx accepted while in RESP.
- Only one outstanding command at a time; the host must wait for the status byte before sending the next packet.

Decomposition:
- Shared package debug_link_pkg holds:
  - opcode constants: OP_PROG = 0x10, OP_CLEAR = 0x20
  - status constants: ST_CMD_OK = 0xA0, ST_PROG_OK = 0xB0, ST_CLR_OK = 0xC0, ST_TIMEOUT = 0xE0, ST_RANGE = 0xE1, ST_BADOP = 0xEF
  - the state enum
  - harness command codes: RUN = 1, STEPI = 2, STEPC = 3
- No sub-module; the timeout counter and byte counter stay inline.

Test Plan:
1. Bytes 0x10, 0x00, 0x04, 0x04, then 0x13, 0x05, 0x00, 0x00 → four single-cycle program_rom_mode strobes at addr 4..7 with data 13/05/00/00; tx 0xB0.
2. Byte 0x01 with a harness model completing 2 cycles later → debug_cmd = 1 for exactly 1 cycle; tx 0xA1.
3. Byte 0x03 with command_complete held 0 → tx 0xE3 exactly TIMEOUT_CYCLES cycles after CMD_WAIT entry; debug_cmd stays 0 afterwards.
4. PROG at addr 30, len 4 → writes at addr 30 and 31 only; addr 32 and 33 suppressed; tx 0xE1.
5. Byte 0x20 → reset_code_rom_n low for 2 cycles; tx 0xC0. Then byte 0x7F → tx 0xEF with no harness activity.
6. Reset asserted during PROG_DATA with tx_ready held 0 → all outputs return to reset values; no tx byte; next 0x02 packet completes normally with tx 0xA2.
